// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Shares the 8-digit seven-segment display between two message requesters
//   using round-robin arbitration. An accepted 32-bit message (8 hex nibbles)
//   is shown for HOLD_TICKS scroll ticks. It rotates left one digit per tick,
//   and then the display is released and blanked.
//
// Parameters
//   CLK_NUM    : clk cycles per scroll tick (>= 2)
//   HOLD_TICKS : scroll ticks per granted message (>= 1)
//
// Ports
//   clk                 : system clock
//   rst                 : asynchronous, active-high reset
//   req_valid[1:0]      : requester i has a message pending (held until accepted)
//   req_data0/1[31:0]   : messages; nibble k is digit k
//   req_ready[1:0]      : one-cycle accept pulse, data sampled in that cycle
//   busy                : high while a message is granted or shown
//   owner               : index of the current/last granted requester
//   o_seg0..o_seg7[7:0] : active-low segments, bit7=a .. bit1=g, bit0=dp
//
// Optional feature (macro SEG_OWNER_DP_EN)
//   When defined, SHOW lights the dp of digit 0 (owner 0) or of digit 7 (owner 1).
//   When undefined, dp is always off.

module seg_display_arbiter #(
    parameter int unsigned CLK_NUM    = 5000000,
    parameter int unsigned HOLD_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    output logic [1:0]  req_ready,
    output logic        busy,
    output logic        owner,
    output logic [7:0]  o_seg0,
    output logic [7:0]  o_seg1,
    output logic [7:0]  o_seg2,
    output logic [7:0]  o_seg3,
    output logic [7:0]  o_seg4,
    output logic [7:0]  o_seg5,
    output logic [7:0]  o_seg6,
    output logic [7:0]  o_seg7
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SHOW
    } state_t;

    state_t      state, state_nxt;
    logic        winner, winner_nxt;
    logic        last_owner;
    logic [31:0] msg;
    logic [31:0] cyc_cnt;
    logic [31:0] tick_cnt;
    logic [2:0]  offset;
    logic        tick;
    logic        last_tick;
    logic [2:0]  digit;
    logic [7:0]  seg [8];

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hFC;
            4'h1: hex7 = 8'h60;
            4'h2: hex7 = 8'hDA;
            4'h3: hex7 = 8'hF2;
            4'h4: hex7 = 8'h66;
            4'h5: hex7 = 8'hB6;
            4'h6: hex7 = 8'hBE;
            4'h7: hex7 = 8'hE0;
            4'h8: hex7 = 8'hFE;
            4'h9: hex7 = 8'hF6;
            4'hA: hex7 = 8'hEE;
            4'hB: hex7 = 8'h3E;
            4'hC: hex7 = 8'h9C;
            4'hD: hex7 = 8'h7A;
            4'hE: hex7 = 8'h9E;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    assign tick      = (cyc_cnt == CLK_NUM - 1);
    // The tick that brings the tick count to HOLD_TICKS is the last SHOW cycle.
    assign last_tick = tick && ((tick_cnt + 32'd1) == HOLD_TICKS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            winner <= 1'b0;
        end else begin
            state  <= state_nxt;
            winner <= winner_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        winner_nxt = winner;
        req_ready  = '0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    // On a tie, the requester that did not own the display last time wins.
                    if (req_valid == 2'b11)
                        winner_nxt = ~last_owner;
                    else
                        winner_nxt = req_valid[1];
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                busy              = 1'b1;
                req_ready[winner] = 1'b1;
                state_nxt         = SHOW;
            end
            SHOW: begin
                busy = 1'b1;
                if (last_tick)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg        <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            offset     <= '0;
            cyc_cnt    <= '0;
            tick_cnt   <= '0;
        end else begin
            if (state == GRANT) begin
                msg        <= winner ? req_data1 : req_data0;
                owner      <= winner;
                last_owner <= winner;
                offset     <= '0;
                cyc_cnt    <= '0;
                tick_cnt   <= '0;
            end else if (state == SHOW) begin
                if (tick) begin
                    cyc_cnt  <= '0;
                    offset   <= offset + 3'd1;
                    tick_cnt <= tick_cnt + 32'd1;
                end else begin
                    cyc_cnt <= cyc_cnt + 32'd1;
                end
            end
        end
    end

    always_comb begin
        digit = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            digit  = 3'(k) + offset;
            seg[k] = (state == SHOW) ? ~hex7(msg[{digit, 2'b00} +: 4]) : 8'hFF;
        end
`ifdef SEG_OWNER_DP_EN
        if (state == SHOW) begin
            if (owner)
                seg[7][0] = 1'b0;
            else
                seg[0][0] = 1'b0;
        end
`endif
    end

    assign o_seg0 = seg[0];
    assign o_seg1 = seg[1];
    assign o_seg2 = seg[2];
    assign o_seg3 = seg[3];
    assign o_seg4 = seg[4];
    assign o_seg5 = seg[5];
    assign o_seg6 = seg[6];
    assign o_seg7 = seg[7];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Testbench for seg_display_arbiter (CLK_NUM=4, HOLD_TICKS=3, plus a
// HOLD_TICKS=9 instance for the rotation wrap). Grants are queued on a
// scoreboard when requests are driven and popped when req_ready appears.
// Each displayed cycle is then compared against a pattern derived from the
// message and the elapsed SHOW cycles.

module tb_seg_display_arbiter;

    localparam int CLK  = 4;
    localparam int HOLD = 3;
`ifdef SEG_OWNER_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    typedef struct packed {
        logic        idx;
        logic [31:0] data;
    } grant_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [31:0] req_data0 = '0;
    logic [31:0] req_data1 = '0;
    logic [1:0]  req_ready;
    logic        busy;
    logic        owner;
    logic [7:0]  seg [8];

    logic [1:0]  rv9 = '0;
    logic [31:0] rd9 = '0;
    logic [1:0]  rr9;
    logic        busy9;
    logic        owner9;
    logic [7:0]  seg9 [8];

    grant_t      sb_q [$];
    logic [7:0]  sb9_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    seg_display_arbiter #(.CLK_NUM(CLK), .HOLD_TICKS(HOLD)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(req_ready), .busy(busy), .owner(owner),
        .o_seg0(seg[0]), .o_seg1(seg[1]), .o_seg2(seg[2]), .o_seg3(seg[3]),
        .o_seg4(seg[4]), .o_seg5(seg[5]), .o_seg6(seg[6]), .o_seg7(seg[7])
    );

    seg_display_arbiter #(.CLK_NUM(CLK), .HOLD_TICKS(9)) u_dut9 (
        .clk(clk), .rst(rst), .req_valid(rv9),
        .req_data0(rd9), .req_data1(32'h0),
        .req_ready(rr9), .busy(busy9), .owner(owner9),
        .o_seg0(seg9[0]), .o_seg1(seg9[1]), .o_seg2(seg9[2]), .o_seg3(seg9[3]),
        .o_seg4(seg9[4]), .o_seg5(seg9[5]), .o_seg6(seg9[6]), .o_seg7(seg9[7])
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_pat(input logic [3:0] n);
        case (n)
            4'h0: return 8'hFC;  4'h1: return 8'h60;
            4'h2: return 8'hDA;  4'h3: return 8'hF2;
            4'h4: return 8'h66;  4'h5: return 8'hB6;
            4'h6: return 8'hBE;  4'h7: return 8'hE0;
            4'h8: return 8'hFE;  4'h9: return 8'hF6;
            4'hA: return 8'hEE;  4'hB: return 8'h3E;
            4'hC: return 8'h9C;  4'hD: return 8'h7A;
            4'hE: return 8'h9E;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input logic [31:0] data, input int k,
                                           input int off, input logic own);
        logic [31:0] sh;
        logic [7:0]  v;
        sh = data >> (4 * ((k + off) % 8));
        v  = ~hex_pat(sh[3:0]);
        if (DP_EN && ((k == 0 && !own) || (k == 7 && own)))
            v[0] = 1'b0;
        return v;
    endfunction

    task automatic push_grant(input logic idx, input logic [31:0] data);
        grant_t g;
        g.idx  = idx;
        g.data = data;
        sb_q.push_back(g);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s_seg%0d", tag, k), seg[k], 8'hFF);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, req_ready, 2'b00);
        check({tag, "_owner"}, owner, 1'b0);
    endtask

    // Waits for the next grant, checks it against the scoreboard, then follows
    // the whole SHOW phase and the following IDLE cycle. If abort_at is a valid
    // SHOW cycle index, reset is raised between edges during that cycle.
    task automatic run_message(input int hold, input logic [1:0] drop, input int abort_at);
        grant_t g;
        bit     seen;
        seen = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("grant_timeout", 64'd0, 64'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            check("sb_empty", {62'd0, req_ready}, 64'd0);
            return;
        end
        g = sb_q.pop_front();
        check("ready", req_ready, 2'b01 << g.idx);
        check("grant_busy", busy, 1'b1);
        req_valid = req_valid & ~drop;
        for (int i = 0; i < hold * CLK; i++) begin
            @(negedge clk);
            check($sformatf("show_busy_c%0d", i), busy, 1'b1);
            check($sformatf("show_owner_c%0d", i), owner, g.idx);
            check($sformatf("show_ready_c%0d", i), req_ready, 2'b00);
            for (int k = 0; k < 8; k++)
                check($sformatf("seg%0d_c%0d", k, i), seg[k], exp_seg(g.data, k, i / CLK, g.idx));
            if (i == abort_at) begin
                #2 rst = 1'b1;
                #1 check_reset_outputs("midshow_rst");
                return;
            end
        end
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", req_ready, 2'b00);
        for (int k = 0; k < 8; k++)
            check($sformatf("idle_seg%0d", k), seg[k], 8'hFF);
    endtask

    initial begin
        // Power-on reset
        #1 rst = 1'b1;
        #3 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single request from requester 0
        req_data0 = 32'h76543210;
        req_valid = 2'b01;
        push_grant(1'b0, req_data0);
        run_message(HOLD, 2'b01, -1);

        // Reset between edges, then simultaneous requests held throughout
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        req_data0 = 32'h89ABCDEF;
        req_data1 = 32'h13579BDF;
        req_valid = 2'b11;
        push_grant(1'b0, req_data0);
        push_grant(1'b1, req_data1);
        push_grant(1'b0, req_data0);
        run_message(HOLD, 2'b00, -1);
        run_message(HOLD, 2'b00, -1);
        run_message(HOLD, 2'b11, -1);

        // Requester 1 raised during SHOW of requester 0: must wait for IDLE
        req_data0 = 32'h0F1E2D3C;
        req_data1 = 32'hC0FFEE42;
        req_valid = 2'b01;
        push_grant(1'b0, req_data0);
        fork
            run_message(HOLD, 2'b01, -1);
            begin
                repeat (6) @(negedge clk);
                req_valid[1] = 1'b1;
                push_grant(1'b1, req_data1);
            end
        join
        run_message(HOLD, 2'b10, -1);

        // Mid-show reset discards the message; both pending -> requester 0 first
        req_data0 = 32'hA5A55A5A;
        req_data1 = 32'h2468ACE0;
        req_valid = 2'b11;
        push_grant(1'b0, req_data0);
        run_message(HOLD, 2'b00, 3);
        @(negedge clk);
        rst = 1'b0;
        push_grant(1'b0, req_data0);
        push_grant(1'b1, req_data1);
        run_message(HOLD, 2'b00, -1);
        run_message(HOLD, 2'b11, -1);

        // Rotation wrap with HOLD_TICKS=9: digit 0 after 8 ticks repeats tick 0
        rd9 = 32'hFEDCBA98;
        rv9 = 2'b01;
        for (int j = 0; j < 9; j++)
            sb9_q.push_back(exp_seg(rd9, 0, j, 1'b0));
        begin
            bit seen9;
            seen9 = 1'b0;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (rr9 != 2'b00) begin
                    seen9 = 1'b1;
                    break;
                end
            end
            if (!seen9) begin
                check("wrap_grant_timeout", 64'd0, 64'd1);
            end else begin
                check("wrap_ready", rr9, 2'b01);
                rv9 = 2'b00;
                for (int i = 0; i < 9 * CLK; i++) begin
                    @(negedge clk);
                    if (i % CLK == 0 && sb9_q.size() != 0)
                        check($sformatf("wrap_seg0_t%0d", i / CLK), seg9[0], sb9_q.pop_front());
                    check($sformatf("wrap_busy_c%0d", i), busy9, 1'b1);
                end
                @(negedge clk);
                check("wrap_idle_busy", busy9, 1'b0);
                check("wrap_idle_seg0", seg9[0], 8'hFF);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
